// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
//   AHB-side initiator for the AHB-to-APB bridge. Commands are queued in a
//   small FIFO and issued one at a time: a one-cycle HSEL address phase,
//   then a data phase that ends when HREADYOUT returns high (the first
//   data-phase cycle is always spent on the bridge's APB setup). One
//   response is returned per command; a data phase that stays stalled for
//   TIMEOUT cycles is aborted with rsp_err.
//
//   Ports
//     HCLK, RESET            clock, synchronous active-high reset
//     cmd_valid/ready        command handshake (write flag, addr, wdata)
//     rsp_valid              one-cycle completion pulse with rsp_write,
//                            rsp_rdata (0 for writes/errors), rsp_err
//     busy                   FSM active or commands queued
//     HSEL/HADDR/HWRITE      address phase towards the bridge
//     HWDATA                 write data during the data phase
//     HREADY                 bus ready, mirrors HREADYOUT
//     HREADYOUT/HRDATA       bridge ready and read data
//
//   state  | meaning
//   IDLE   | waiting for a queued command and a ready bridge
//   ADDR   | HSEL high, single address-phase cycle
//   DATA   | waiting for HREADYOUT (after the setup cycle) or timeout
module ahb_cmd_master #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              HCLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  input  logic              HREADYOUT,
  input  logic [DATA_W-1:0] HRDATA
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic              r_fifo_wr   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_wd   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_first;
  logic [DATA_W-1:0] r_wdata;

  logic              r_hsel;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_empty;
  logic w_push;
  logic w_launch;
  logic w_done;
  logic w_tmo;
  logic w_cnt_inc;

  // The full test uses the pre-edge count, so a full FIFO refuses a push
  // even in a cycle where the FSM pops.
  assign w_empty   = (r_count == '0);
  assign cmd_ready = !RESET && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push    = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && HREADYOUT) begin
          w_launch    = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (HREADYOUT) begin
          // HREADYOUT during the setup cycle does not end the transfer.
          if (!r_first) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cmd_addr;
      r_fifo_wr[r_wr_ptr]   <= cmd_write;
      r_fifo_wd[r_wr_ptr]   <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tmo_cnt   <= '0;
      r_first     <= 1'b0;
      r_wdata     <= '0;
      r_hsel      <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_launch) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_launch);

      r_rsp_valid <= w_done || w_tmo;

      if (w_launch) begin
        r_hsel   <= 1'b1;
        r_haddr  <= r_fifo_addr[r_rd_ptr];
        r_hwrite <= r_fifo_wr[r_rd_ptr];
        r_wdata  <= r_fifo_wd[r_rd_ptr];
      end

      if (r_state == S_ADDR) begin
        r_hsel    <= 1'b0;
        r_tmo_cnt <= '0;
        r_first   <= 1'b1;
        // Reads leave HWDATA at the last written value.
        if (r_hwrite) r_hwdata <= r_wdata;
      end

      if (r_state == S_DATA) begin
        r_first <= 1'b0;
        if (w_cnt_inc) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_done) begin
        r_rsp_write <= r_hwrite;
        r_rsp_rdata <= r_hwrite ? '0 : HRDATA;
        r_rsp_err   <= 1'b0;
      end

      if (w_tmo) begin
        r_rsp_write <= r_hwrite;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign HREADY    = HREADYOUT;
  assign HSEL      = r_hsel;
  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master
//   Directed plus randomized bench for ahb_cmd_master. A bridge/APB-slave
//   model answers each transfer with a per-command number of stall cycles;
//   expected responses (data, error flag and arrival cycle) come from a
//   reference memory and the timing rules of the command master.
module tb_ahb_cmd_master;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          HCLK = 1'b0;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [DW-1:0] HRDATA;

  ahb_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TMO)
  ) dut (
    .HCLK(HCLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  // per-command expectations, indexed by acceptance order
  logic          e_wr   [256];
  logic [AW-1:0] e_addr [256];
  logic [DW-1:0] e_wd   [256];
  logic [DW-1:0] e_rd   [256];
  logic          e_err  [256];
  int            e_w    [256];
  int            e_due  [256];

  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] br_mem  [128];

  int  push_idx, br_idx, rsp_idx, cyc, br_cnt, br_cur;
  bit  br_busy, br_first, hsel_prev, hr_prev, idle_stall;
  logic [DW-1:0] last_wd;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic record(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int w);
    e_wr[push_idx]   = wr;
    e_addr[push_idx] = a;
    e_wd[push_idx]   = d;
    e_w[push_idx]    = w;
    e_err[push_idx]  = (w >= TMO);
    e_rd[push_idx]   = (wr || w >= TMO) ? '0 : ref_mem[a];
    if (wr && w < TMO) ref_mem[a] = d;
    push_idx++;
  endtask

  // Bridge + APB slave model and response/protocol monitor.
  // Runs 1 time unit after every rising edge.
  task automatic env_loop();
    forever begin
      @(posedge HCLK);
      #1;
      cyc++;
      if (RESET) begin
        chk("rst_hsel", HSEL, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_write", rsp_write, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        br_busy   = 1'b0;
        HREADYOUT = 1'b1;
        rsp_idx   = br_idx;
        last_wd   = '0;
        hsel_prev = 1'b0;
        hr_prev   = 1'b1;
      end else begin
        if (HSEL) begin
          chk("hsel_width", hsel_prev, 0);
          chk("hsel_while_stalled", hr_prev, 1);
          chk("hsel_overlap", rsp_idx, br_idx);
          if (br_idx < push_idx) begin
            chk("haddr", HADDR, e_addr[br_idx]);
            chk("hwrite", HWRITE, e_wr[br_idx]);
            br_cur    = br_idx;
            br_idx++;
            br_busy   = 1'b1;
            br_first  = 1'b1;
            br_cnt    = e_w[br_cur];
            HREADYOUT = 1'b0;
            e_due[br_cur] = cyc + ((e_w[br_cur] >= TMO) ? TMO + 1 :
                                   ((e_w[br_cur] < 1) ? 1 : e_w[br_cur]) + 2);
          end else begin
            chk("hsel_unexpected", br_idx, push_idx - 1);
          end
        end else if (br_busy) begin
          if (br_first) begin
            chk("hwdata", HWDATA, e_wr[br_cur] ? e_wd[br_cur] : last_wd);
            chk("haddr_hold", HADDR, e_addr[br_cur]);
            chk("hwrite_hold", HWRITE, e_wr[br_cur]);
            if (e_wr[br_cur]) last_wd = e_wd[br_cur];
            br_first = 1'b0;
          end
          if (br_cnt > 0) begin
            br_cnt--;
          end else begin
            HREADYOUT = 1'b1;
            br_busy   = 1'b0;
            if (e_wr[br_cur]) br_mem[e_addr[br_cur]] = HWDATA;
            else              HRDATA = br_mem[e_addr[br_cur]];
          end
        end else begin
          HREADYOUT = !idle_stall;
        end

        if (rsp_valid) begin
          if (rsp_idx < push_idx) begin
            chk("rsp_write", rsp_write, e_wr[rsp_idx]);
            chk("rsp_err", rsp_err, e_err[rsp_idx]);
            chk("rsp_rdata", rsp_rdata, e_rd[rsp_idx]);
            chk("rsp_cycle", cyc, e_due[rsp_idx]);
            rsp_idx++;
          end else begin
            chk("rsp_unexpected", rsp_valid, 0);
          end
        end
        hsel_prev = HSEL;
        hr_prev   = HREADYOUT;
      end
    end
  endtask

  task automatic offer(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int w);
    int n;
    n = 0;
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 500) begin
      @(negedge HCLK);
      n++;
    end
    chk("offer_accept", cmd_ready, 1);
    if (cmd_ready) record(wr, a, d, w);
    @(posedge HCLK);
  endtask

  task automatic drop();
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000 && !(rsp_idx == push_idx && !busy && !br_busy)) begin
      @(negedge HCLK);
      n++;
    end
    chk("drain", (n < 3000), 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int saved;
    RESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; HREADYOUT = 1'b1; HRDATA = '0;
    idle_stall = 1'b0; push_idx = 0; br_idx = 0; rsp_idx = 0; cyc = 0;
    br_cnt = 0; br_cur = 0; br_busy = 1'b0; br_first = 1'b0;
    hsel_prev = 1'b0; hr_prev = 1'b1; last_wd = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = '0;
      br_mem[i]  = '0;
    end
    fork
      env_loop();
    join_none

    repeat (3) @(negedge HCLK);
    chk("rst_ready_held", cmd_ready, 0);
    RESET = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    // single write: latency and bridge contents
    offer(1'b1, 7'h25, 32'hDEAD_BEEF, 1);
    drop();
    chk("lat_hsel_k", HSEL, 0);
    @(negedge HCLK);
    chk("lat_hsel_k1", HSEL, 1);
    chk("lat_haddr", HADDR, 7'h25);
    chk("lat_hwrite", HWRITE, 1);
    wait_idle();
    chk("slave1_paddr05", br_mem[7'h25], 32'hDEAD_BEEF);

    // read back the same address
    offer(1'b0, 7'h25, '0, 3);
    drop();
    wait_idle();
    chk("rd_back", rsp_rdata, 32'hDEAD_BEEF);

    // fill the FIFO with the bridge stalled in IDLE
    @(negedge HCLK);
    idle_stall = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("stall_hready", HREADY, 0);
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      offer(1'b1, AW'(7'h10 + i), d, i);
    end
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h11; cmd_wdata = '0;
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    repeat (3) begin
      @(negedge HCLK);
      chk("full_ready_hold", cmd_ready, 0);
      chk("stall_no_hsel", HSEL, 0);
    end
    idle_stall = 1'b0;
    @(negedge HCLK);
    chk("unstall_hsel_wait", HSEL, 0);
    chk("unstall_ready_wait", cmd_ready, 0);
    @(negedge HCLK);
    chk("unstall_hsel", HSEL, 1);
    chk("pop_ready", cmd_ready, 1);
    record(1'b0, 7'h11, '0, 2);
    @(posedge HCLK);
    drop();
    wait_idle();

    // timeout boundary: 15 stalled cycles complete, 16 abort
    offer(1'b0, 7'h41, '0, TMO - 1);
    drop();
    wait_idle();
    offer(1'b0, 7'h42, '0, TMO);
    drop();
    wait_idle();
    chk("err_held", rsp_err, 1);
    chk("tmo_idle", busy, 0);
    offer(1'b1, 7'h42, 32'hA5A5_0F0F, 2);
    drop();
    wait_idle();
    chk("err_cleared", rsp_err, 0);

    // reset during the data phase of a read, with one command queued
    offer(1'b0, 7'h25, '0, 10);
    offer(1'b0, 7'h10, '0, 0);
    drop();
    for (int i = 0; i < 50 && !(br_busy && !HSEL && !HREADYOUT); i++)
      @(negedge HCLK);
    @(negedge HCLK);
    saved = br_idx;
    RESET = 1'b1;
    @(negedge HCLK);
    RESET = 1'b0;
    push_idx = br_idx;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_hwdata", HWDATA, 0);
    repeat (20) @(negedge HCLK);
    chk("rst_discard", br_idx, saved);
    chk("rst_no_rsp", rsp_idx, push_idx);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      offer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), d,
            int'($urandom_range(0, 4)));
      if ($urandom_range(0, 2) == 0) drop();
    end
    drop();
    wait_idle();
    chk("final_idle", busy, 0);
    chk("final_rsp_count", rsp_idx, push_idx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
